ghazi_ram_arbiter: RTL

- Shares one single-port DFFRAM macro (32-bit words, byte-enabled, 1-cycle read latency) between two requesters:
  - the management-core Wishbone slave port of the user area;
  - the Ghazi core's memory request port.
- Round-robin arbitration, one transaction at a time, with a fixed four-state sequence per access.
- Allows the host to preload or inspect program memory while the core runs or is held off.

---
 rtl/ghazi_ram_arb_pkg.sv | 19 +
 rtl/ghazi_rr_arb2.sv | 39 +++
 rtl/ghazi_ram_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ghazi_ram_arb_pkg.sv
// Shared types and constants for the Ghazi RAM arbiter: FSM states,
// requester identities and the default Wishbone window base.
package ghazi_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic {
    HOST,
    CORE
  } grant_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/ghazi_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen. last_grant only advances when update_en is high.
module ghazi_rr_arb2
  import ghazi_ram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_host,
  input  logic   req_core,
  input  logic   update_en,
  output logic   valid,
  output grant_e pick
);

  grant_e last_q, last_d;

  always_comb begin
    valid = req_host | req_core;
    if (req_host && req_core) begin
      pick = (last_q == HOST) ? CORE : HOST;
    end else if (req_core) begin
      pick = CORE;
    end else begin
      pick = HOST;
    end
    last_d = (update_en && valid) ? pick : last_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= HOST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ghazi_ram_arbiter.sv
// Shares one single-port byte-enabled RAM between the Wishbone host window and
// the Ghazi core port; each access runs IDLE -> ISSUE -> WAIT -> DONE.
module ghazi_ram_arbiter
  import ghazi_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              cfg_core_en_i,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  arb_state_e        state_q, state_d;
  grant_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              wbs_ack_q, wbs_ack_d;
  logic [31:0]       wbs_dat_q, wbs_dat_d;
  logic              core_gnt_q, core_gnt_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic [31:0]       core_rdata_q, core_rdata_d;

  logic   win_hit, host_req, host_miss, core_ok;
  logic   arb_valid;
  grant_e arb_pick;
  logic   arb_update;
  logic [31:0] rsp;

  assign win_hit   = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign host_req  = wbs_cyc_i & wbs_stb_i & win_hit;
  assign host_miss = wbs_cyc_i & wbs_stb_i & ~win_hit;
  assign core_ok   = core_req_i & cfg_core_en_i;
  assign arb_update = (state_q == IDLE);

  // Byte-lane bits of the Wishbone address never reach the word-addressed RAM.
  logic unused_adr;
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  ghazi_rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_host  (host_req),
    .req_core  (core_ok),
    .update_en (arb_update),
    .valid     (arb_valid),
    .pick      (arb_pick)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    mem_en_d      = 1'b0;
    mem_we_d      = '0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wbs_ack_d     = 1'b0;
    wbs_dat_d     = wbs_dat_q;
    core_gnt_d    = 1'b0;
    core_rvalid_d = 1'b0;
    core_rdata_d  = core_rdata_q;
    rsp           = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d  = arb_pick;
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (arb_pick == HOST) begin
            we_d        = wbs_we_i;
            mem_we_d    = wbs_we_i ? wbs_sel_i : 4'h0;
            mem_addr_d  = wbs_adr_i[ADDR_W+1:2];
            mem_wdata_d = wbs_dat_i;
          end else begin
            we_d        = core_we_i;
            mem_we_d    = core_we_i ? core_be_i : 4'h0;
            mem_addr_d  = core_addr_i;
            mem_wdata_d = core_wdata_i;
            core_gnt_d  = 1'b1;
          end
        end else if (host_miss) begin
          // Out-of-window host access completes without touching the RAM.
          owner_d   = HOST;
          wbs_ack_d = 1'b1;
          wbs_dat_d = '0;
          state_d   = DONE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp     = we_q ? 32'h0 : mem_rdata_i;
        state_d = DONE;
        if (owner_q == HOST) begin
          wbs_ack_d = 1'b1;
          wbs_dat_d = rsp;
        end else begin
          core_rvalid_d = 1'b1;
          core_rdata_d  = rsp;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      owner_q       <= HOST;
      we_q          <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wbs_ack_q     <= 1'b0;
      wbs_dat_q     <= '0;
      core_gnt_q    <= 1'b0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wbs_ack_q     <= wbs_ack_d;
      wbs_dat_q     <= wbs_dat_d;
      core_gnt_q    <= core_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
    end
  end

  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign wbs_ack_o     = wbs_ack_q;
  assign wbs_dat_o     = wbs_dat_q;
  assign core_gnt_o    = core_gnt_q;
  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = core_rdata_q;

endmodule
